// File: rtl/multilane_piped_mac.sv
// rtl/multilane_piped_mac.sv - multi-lane pipelined stream MAC with result FIFO and credit flow control
module multilane_piped_mac #(
  parameter int LANES     = 1,
  parameter int IN_W      = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_DEPTH = 4,
  parameter int SAT       = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  output logic                    SD_AXIS_TREADY,
  input  logic                    SD_AXIS_TVALID,
  input  logic [2*LANES*IN_W-1:0] SD_AXIS_TDATA,
  input  logic                    SD_AXIS_TLAST,
  input  logic [31:0]             SD_AXIS_TUSER,
  output logic                    MO_AXIS_TVALID,
  output logic [ACC_W-1:0]        MO_AXIS_TDATA,
  output logic                    MO_AXIS_TLAST,
  input  logic                    MO_AXIS_TREADY
);

  localparam int DW = 2 * LANES * IN_W;
  localparam int PW = 2 * IN_W;
  localparam int SW = PW + $clog2(LANES);
  localparam int XW = ((ACC_W > SW) ? ACC_W : SW) + 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int AW = $clog2(OUT_DEPTH);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ST_BIAS, ST_ACCUM} state_t;

  state_t state, state_next;

  logic                    accept;
  logic                    bias_accept;
  logic                    pop;
  logic [CW-1:0]           credits;
  logic                    relu_q;
  logic signed [ACC_W-1:0] bias_in;
  logic signed [PW-1:0]    prod [LANES];
  logic                    unused_tuser;

  logic                    s1_valid, s1_bias, s1_last, s1_relu;
  logic signed [ACC_W-1:0] s1_bias_val;
  logic signed [PW-1:0]    s1_prod [LANES];

  logic signed [SW-1:0]    lane_sum;
  logic                    s2_valid, s2_bias, s2_last, s2_relu;
  logic signed [ACC_W-1:0] s2_bias_val;
  logic signed [SW-1:0]    s2_sum;

  logic signed [XW-1:0]    sum_wide;
  logic signed [ACC_W-1:0] add_res;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] acc;
  logic                    res_valid;
  logic [ACC_W-1:0]        res_data;

  logic [ACC_W-1:0]        fifo_mem [OUT_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count;

  assign unused_tuser = ^SD_AXIS_TUSER[31:1];

  assign accept      = SD_AXIS_TVALID && SD_AXIS_TREADY;
  assign bias_accept = accept && (state == ST_BIAS);
  assign pop         = MO_AXIS_TVALID && MO_AXIS_TREADY;

  // Bias beat is sign-extended when narrower than the accumulator, else truncated
  generate
    if (DW >= ACC_W) begin : g_bias_trunc
      assign bias_in = SD_AXIS_TDATA[ACC_W-1:0];
    end else begin : g_bias_sext
      assign bias_in = ACC_W'($signed(SD_AXIS_TDATA));
    end
  endgenerate

  // Input FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_BIAS;
    else        state <= state_next;
  end

  // Next state: TLAST always returns to BIAS, any other accepted beat goes to ACCUM
  always_comb begin
    state_next = state;
    if (accept) state_next = SD_AXIS_TLAST ? ST_BIAS : ST_ACCUM;
  end

  // Ready: mid-packet beats never stall; a new packet needs a free result slot
  always_comb begin
    SD_AXIS_TREADY = 1'b0;
    if (!ARESET) begin
      if (state == ST_ACCUM) SD_AXIS_TREADY = 1'b1;
      else                   SD_AXIS_TREADY = (credits < CW'(OUT_DEPTH));
    end
  end

  // Credits count packets between bias accept and result pop
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      credits <= '0;
    end else if (bias_accept && !pop) begin
      credits <= credits + CW'(1);
    end else if (!bias_accept && pop) begin
      credits <= credits - CW'(1);
    end
  end

  // ReLU enable is captured from the bias beat and applied to the whole packet
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)           relu_q <= 1'b0;
    else if (bias_accept) relu_q <= SD_AXIS_TUSER[0];
  end

  // Per-lane signed products of the incoming beat
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PW'($signed(SD_AXIS_TDATA[(2*k+1)*IN_W +: IN_W]))
              * PW'($signed(SD_AXIS_TDATA[2*k*IN_W +: IN_W]));
    end
  end

  // Stage 1: products, bias value and beat tags
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s1_valid    <= 1'b0;
      s1_bias     <= 1'b0;
      s1_last     <= 1'b0;
      s1_relu     <= 1'b0;
      s1_bias_val <= '0;
      for (int k = 0; k < LANES; k++) s1_prod[k] <= '0;
    end else begin
      s1_valid    <= accept;
      s1_bias     <= bias_accept;
      s1_last     <= SD_AXIS_TLAST;
      s1_relu     <= bias_accept ? SD_AXIS_TUSER[0] : relu_q;
      s1_bias_val <= bias_in;
      for (int k = 0; k < LANES; k++) s1_prod[k] <= prod[k];
    end
  end

  // Lane adder tree, wide enough that the sum of all lanes cannot overflow
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) lane_sum = lane_sum + SW'(s1_prod[k]);
  end

  // Stage 2: lane sum with tags
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s2_valid    <= 1'b0;
      s2_bias     <= 1'b0;
      s2_last     <= 1'b0;
      s2_relu     <= 1'b0;
      s2_bias_val <= '0;
      s2_sum      <= '0;
    end else begin
      s2_valid    <= s1_valid;
      s2_bias     <= s1_bias;
      s2_last     <= s1_last;
      s2_relu     <= s1_relu;
      s2_bias_val <= s1_bias_val;
      s2_sum      <= lane_sum;
    end
  end

  // Accumulate at extended width so clamping sees the true sum before truncation
  always_comb begin
    sum_wide = XW'(acc) + XW'(s2_sum);
    add_res  = sum_wide[ACC_W-1:0];
    if (SAT != 0) begin
      if (sum_wide > XW'(ACC_MAX))      add_res = ACC_MAX;
      else if (sum_wide < XW'(ACC_MIN)) add_res = ACC_MIN;
    end
    acc_next = s2_bias ? s2_bias_val : add_res;
  end

  // Stage 3: accumulator and finished result (ReLU applied on the final value)
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      acc       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        acc <= acc_next;
        if (s2_last) res_data <= (s2_relu && acc_next[ACC_W-1]) ? '0 : acc_next;
      end
    end
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Result FIFO storage; credits guarantee a free slot for every write
  always_ff @(posedge ACLK) begin
    if (res_valid) fifo_mem[wr_ptr] <= res_data;
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (res_valid) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)       rd_ptr <= ptr_inc(rd_ptr);
      if (res_valid && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!res_valid && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  // FIFO head drives the output stream; data forced to zero while empty
  always_comb begin
    MO_AXIS_TVALID = |fifo_count;
    MO_AXIS_TLAST  = MO_AXIS_TVALID;
    MO_AXIS_TDATA  = MO_AXIS_TVALID ? fifo_mem[rd_ptr] : '0;
  end

endmodule
